// File: rtl/spi_ip_pkg.sv
// Shared types and constants for the SPI master IP: FSM encoding,
// divider selects and {pol, pha} mode codes.
package spi_ip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LAST  = 3'd3,
    ST_HOLD  = 3'd4
  } xfer_state_e;

  localparam logic [2:0] CLK_2   = 3'd0;
  localparam logic [2:0] CLK_4   = 3'd1;
  localparam logic [2:0] CLK_8   = 3'd2;
  localparam logic [2:0] CLK_16  = 3'd3;
  localparam logic [2:0] CLK_32  = 3'd4;
  localparam logic [2:0] CLK_64  = 3'd5;
  localparam logic [2:0] CLK_128 = 3'd6;
  localparam logic [2:0] CLK_256 = 3'd7;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_ip_shift_reg.sv
// Bidirectional word shifter: tx word presented bit-serially on mosi,
// rx word assembled from miso, both in MSB- or LSB-first order.
module spi_ip_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              lsb_first,
  input  logic              shift,
  input  logic              sample,
  input  logic              miso,
  output logic              mosi,
  output logic [DATA_W-1:0] rx_data
);

  logic [DATA_W-1:0] tx_r;
  logic [DATA_W-1:0] rx_r;
  logic              lsb_r;

  // Transmit word: zero-filled as bits leave; clear parks mosi low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_r  <= '0;
      lsb_r <= 1'b0;
    end else if (clear) begin
      tx_r  <= '0;
    end else if (load) begin
      tx_r  <= load_data;
      lsb_r <= lsb_first;
    end else if (shift) begin
      tx_r  <= lsb_r ? {1'b0, tx_r[DATA_W-1:1]} : {tx_r[DATA_W-2:0], 1'b0};
    end
  end

  // Receive word: new bits enter opposite the end that is sent first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_r <= '0;
    end else if (sample) begin
      rx_r <= lsb_r ? {miso, rx_r[DATA_W-1:1]} : {rx_r[DATA_W-2:0], miso};
    end
  end

  assign mosi    = lsb_r ? tx_r[0] : tx_r[DATA_W-1];
  assign rx_data = rx_r;

endmodule

// File: rtl/spi_ip_tick_gen.sv
// SCK half-period tick generator: divides clk by 2^(n+1), toggles SCK and
// classifies each tick as a launch or capture edge according to CPHA.
module spi_ip_tick_gen (
  input  logic       tg_clk_i,
  input  logic       tg_rst_n_i,
  input  logic       tg_enable_tick_i,
  input  logic       tg_enable_sck_i,
  input  logic       tg_enable_launch_capture_i,
  input  logic       tg_sck_pol_i,
  input  logic       tg_sck_pha_i,
  input  logic [2:0] tg_clk_div_i,
  output logic       tg_tick_o,
  output logic       tg_tick_launch_o,
  output logic       tg_tick_capture_o,
  output logic       tg_sck_o
);

  logic [7:0] half_m1_s;
  logic [7:0] div_cnt_r;
  logic       tick_r;
  logic       sck_r;
  logic       lead_s;

  assign half_m1_s = (8'd1 << tg_clk_div_i) - 8'd1;

  // Half-period counter; restarts whenever the tick enable is low
  always_ff @(posedge tg_clk_i or negedge tg_rst_n_i) begin
    if (!tg_rst_n_i) begin
      div_cnt_r <= 8'd0;
      tick_r    <= 1'b0;
    end else if (!tg_enable_tick_i) begin
      div_cnt_r <= 8'd0;
      tick_r    <= 1'b0;
    end else if (div_cnt_r == half_m1_s) begin
      div_cnt_r <= 8'd0;
      tick_r    <= 1'b1;
    end else begin
      div_cnt_r <= div_cnt_r + 8'd1;
      tick_r    <= 1'b0;
    end
  end

  // SCK parks at CPOL while disabled and toggles on every tick otherwise
  always_ff @(posedge tg_clk_i or negedge tg_rst_n_i) begin
    if (!tg_rst_n_i) begin
      sck_r <= 1'b0;
    end else if (!tg_enable_sck_i) begin
      sck_r <= tg_sck_pol_i;
    end else if (tick_r) begin
      sck_r <= ~sck_r;
    end
  end

  // A tick taken while SCK sits at CPOL is the leading edge of a pulse
  assign lead_s            = (sck_r == tg_sck_pol_i);
  assign tg_tick_o         = tick_r;
  assign tg_sck_o          = sck_r;
  assign tg_tick_launch_o  = tick_r & tg_enable_launch_capture_i & (tg_sck_pha_i ? lead_s : ~lead_s);
  assign tg_tick_capture_o = tick_r & tg_enable_launch_capture_i & (tg_sck_pha_i ? ~lead_s : lead_s);

endmodule

// File: rtl/spi_ip_xfer_ctrl.sv
// SPI master word-transfer sequencer: owns chip-select, the tick-generator
// enables and the latched mode/divider; one DATA_W word per start.
module spi_ip_xfer_ctrl
  import spi_ip_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CS_SETUP = 1,
  parameter int CS_HOLD  = 1
) (
  input  logic              xc_clk_i,
  input  logic              xc_rst_n_i,
  input  logic              xc_start_i,
  input  logic              xc_abort_i,
  input  logic [DATA_W-1:0] xc_tx_data_i,
  input  logic              xc_lsb_first_i,
  input  logic              xc_sck_pol_i,
  input  logic              xc_sck_pha_i,
  input  logic [2:0]        xc_clk_div_i,
  input  logic              xc_miso_i,
  input  logic              xc_tick_i,
  input  logic              xc_tick_launch_i,
  input  logic              xc_tick_capture_i,
  output logic              xc_enable_tick_o,
  output logic              xc_enable_sck_o,
  output logic              xc_enable_lc_o,
  output logic              xc_sck_pol_o,
  output logic              xc_sck_pha_o,
  output logic [2:0]        xc_clk_div_o,
  output logic              xc_cs_n_o,
  output logic              xc_mosi_o,
  output logic              xc_busy_o,
  output logic              xc_done_o,
  output logic [DATA_W-1:0] xc_rx_data_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int TCK_W = $clog2(max2(CS_SETUP, CS_HOLD) + 1);

  xfer_state_e       state_r, state_s;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [TCK_W-1:0]  tick_cnt_r;
  logic              pending_r;
  logic              cs_n_r, en_tick_r, en_sck_r, en_lc_r, busy_r, done_r;
  logic              pol_r, pha_r;
  logic [2:0]        div_r;
  logic [DATA_W-1:0] rx_data_r;
  logic [DATA_W-1:0] rx_shift_s;
  logic              accept_s, abort_s, setup_done_s, last_cap_s, last_tick_s, hold_done_s;
  logic              sample_s, shift_s, mosi_s;

  // Next-state decode and per-cycle strobes
  always_comb begin
    state_s      = state_r;
    accept_s     = 1'b0;
    abort_s      = 1'b0;
    setup_done_s = 1'b0;
    last_cap_s   = 1'b0;
    last_tick_s  = 1'b0;
    hold_done_s  = 1'b0;
    sample_s     = 1'b0;
    shift_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (xc_start_i && !xc_abort_i) begin
          accept_s = 1'b1;
          state_s  = ST_SETUP;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (xc_tick_i && (tick_cnt_r == TCK_W'(CS_SETUP - 1))) begin
          setup_done_s = 1'b1;
          state_s      = ST_SHIFT;
        end else begin
          state_s      = ST_SETUP;
        end
      end
      ST_SHIFT: begin
        // A launch coinciding with a capture is not consumed
        sample_s = xc_tick_capture_i;
        shift_s  = xc_tick_launch_i && pending_r && !xc_tick_capture_i;
        if (xc_tick_capture_i && (bit_cnt_r == CNT_W'(DATA_W - 1))) begin
          last_cap_s = 1'b1;
          state_s    = pha_r ? ST_HOLD : ST_LAST;
        end else begin
          state_s    = ST_SHIFT;
        end
      end
      ST_LAST: begin
        if (xc_tick_i) begin
          last_tick_s = 1'b1;
          state_s     = ST_HOLD;
        end else begin
          state_s     = ST_LAST;
        end
      end
      ST_HOLD: begin
        if (xc_tick_i && (tick_cnt_r == TCK_W'(CS_HOLD - 1))) begin
          hold_done_s = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          state_s     = ST_HOLD;
        end
      end
      default: state_s = ST_IDLE;
    endcase
    if (xc_abort_i && (state_r != ST_IDLE)) begin
      abort_s = 1'b1;
      state_s = ST_IDLE;
    end else begin
      abort_s = 1'b0;
    end
  end

  // State register
  always_ff @(posedge xc_clk_i or negedge xc_rst_n_i) begin
    if (!xc_rst_n_i) state_r <= ST_IDLE;
    else             state_r <= state_s;
  end

  // Registered pad/tick-gen controls, latched config and completion
  always_ff @(posedge xc_clk_i or negedge xc_rst_n_i) begin
    if (!xc_rst_n_i) begin
      cs_n_r    <= 1'b1;
      en_tick_r <= 1'b0;
      en_sck_r  <= 1'b0;
      en_lc_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pol_r     <= 1'b0;
      pha_r     <= 1'b0;
      div_r     <= 3'd0;
      rx_data_r <= '0;
    end else begin
      done_r <= 1'b0;
      if (abort_s) begin
        cs_n_r    <= 1'b1;
        en_tick_r <= 1'b0;
        en_sck_r  <= 1'b0;
        en_lc_r   <= 1'b0;
        busy_r    <= 1'b0;
      end else if (accept_s) begin
        cs_n_r    <= 1'b0;
        en_tick_r <= 1'b1;
        busy_r    <= 1'b1;
        pol_r     <= xc_sck_pol_i;
        pha_r     <= xc_sck_pha_i;
        div_r     <= xc_clk_div_i;
      end else if (setup_done_s) begin
        en_sck_r  <= 1'b1;
        en_lc_r   <= 1'b1;
      end else if ((last_cap_s && pha_r) || last_tick_s) begin
        en_sck_r  <= 1'b0;
        en_lc_r   <= 1'b0;
      end else if (hold_done_s) begin
        cs_n_r    <= 1'b1;
        en_tick_r <= 1'b0;
        busy_r    <= 1'b0;
        done_r    <= 1'b1;
        rx_data_r <= rx_shift_s;
      end
    end
  end

  // Bit counter, launch-pending flag and CS setup/hold tick counter
  always_ff @(posedge xc_clk_i or negedge xc_rst_n_i) begin
    if (!xc_rst_n_i) begin
      bit_cnt_r  <= '0;
      pending_r  <= 1'b0;
      tick_cnt_r <= '0;
    end else if (abort_s || accept_s) begin
      bit_cnt_r  <= '0;
      pending_r  <= 1'b0;
      tick_cnt_r <= '0;
    end else begin
      if (sample_s) begin
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
        pending_r <= 1'b1;
      end else if (shift_s) begin
        pending_r <= 1'b0;
      end
      if (setup_done_s || hold_done_s) begin
        tick_cnt_r <= '0;
      end else if (xc_tick_i && ((state_r == ST_SETUP) || (state_r == ST_HOLD))) begin
        tick_cnt_r <= tick_cnt_r + TCK_W'(1);
      end
    end
  end

  spi_ip_shift_reg #(.DATA_W(DATA_W)) u_shift (
    .clk       (xc_clk_i),
    .rst_n     (xc_rst_n_i),
    .clear     (abort_s || hold_done_s),
    .load      (accept_s),
    .load_data (xc_tx_data_i),
    .lsb_first (xc_lsb_first_i),
    .shift     (shift_s),
    .sample    (sample_s),
    .miso      (xc_miso_i),
    .mosi      (mosi_s),
    .rx_data   (rx_shift_s)
  );

  assign xc_enable_tick_o = en_tick_r;
  assign xc_enable_sck_o  = en_sck_r;
  assign xc_enable_lc_o   = en_lc_r;
  assign xc_sck_pol_o     = pol_r;
  assign xc_sck_pha_o     = pha_r;
  assign xc_clk_div_o     = div_r;
  assign xc_cs_n_o        = cs_n_r;
  assign xc_mosi_o        = mosi_s;
  assign xc_busy_o        = busy_r;
  assign xc_done_o        = done_r;
  assign xc_rx_data_o     = rx_data_r;

endmodule
